// File: rtl/bcnn_pkg.sv
// bcnn_pkg: shared frame geometry, streamer state encoding and width helper
package bcnn_pkg;
  localparam int DEF_IMG_WIDTH  = 28;
  localparam int DEF_IMG_HEIGHT = 28;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} stream_state_t;
  function automatic int clog2(input int v);
    int n = 0;
    while ((1 << n) < v) n++;
    return n;
  endfunction
endpackage

// File: rtl/bcnn_row_buffer.sv
// bcnn_row_buffer: frame store with a row-wide write port and a registered single-pixel read
module bcnn_row_buffer import bcnn_pkg::*; #(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ROW_W      = 5,
  parameter int COL_W      = clog2(DEF_IMG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ROW_W-1:0]     wr_row,
  input  logic [IMG_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ROW_W-1:0]     rd_row,
  input  logic [COL_W-1:0]     rd_col,
  output logic                 rd_bit
);
  logic [IMG_WIDTH-1:0] mem [IMG_HEIGHT];
  // Storage survives reset so a frame can be replayed after an abort.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_row] <= wr_data;
  always_ff @(posedge clk)
    if (!reset) rd_bit <= 1'b0;
    else if (rd_en) rd_bit <= mem[rd_row][rd_col];
endmodule

// File: rtl/bcnn_frame_streamer.sv
// bcnn_frame_streamer: serializes a buffered binary frame as a row-major pixel stream
module bcnn_frame_streamer import bcnn_pkg::*; #(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ROW_W      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ROW_W-1:0]     wr_row,
  input  logic [IMG_WIDTH-1:0] wr_data,
  output logic                 wr_err,
  input  logic                 start,
  input  logic                 pause,
  output logic                 pixel_out,
  output logic                 valid_out,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int COL_W = clog2(IMG_WIDTH);
  stream_state_t state, state_n;
  logic [ROW_W-1:0] r, r_n;
  logic [COL_W-1:0] c, c_n;
  logic valid_n, done_n, rd_en, wr_ok, last_col, last_row;
  assign wr_ok    = wr_en && state == IDLE && ({1'b0, wr_row} < (ROW_W + 1)'(IMG_HEIGHT));
  assign last_col = c == COL_W'(IMG_WIDTH - 1);
  assign last_row = r == ROW_W'(IMG_HEIGHT - 1);
  // The read register doubles as pixel_out, so a paused stream holds its last pixel.
  bcnn_row_buffer #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .ROW_W(ROW_W), .COL_W(COL_W)) u_buf (
    .clk(clk), .reset(reset), .wr_en(wr_ok), .wr_row(wr_row), .wr_data(wr_data),
    .rd_en(rd_en), .rd_row(r), .rd_col(c), .rd_bit(pixel_out)
  );
  always_comb begin
    state_n = state;
    r_n     = r;
    c_n     = c;
    valid_n = 1'b0;
    done_n  = 1'b0;
    rd_en   = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = STREAM;
        r_n     = '0;
        c_n     = '0;
      end
      STREAM: if (!pause) begin
        rd_en   = 1'b1;
        valid_n = 1'b1;
        c_n     = last_col ? '0 : c + 1'b1;
        r_n     = (last_col && !last_row) ? r + 1'b1 : r;
        state_n = (last_col && last_row) ? DONE : STREAM;
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state      <= IDLE;
      r          <= '0;
      c          <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      state      <= state_n;
      r          <= r_n;
      c          <= c_n;
      valid_out  <= valid_n;
      frame_done <= done_n;
      busy       <= state_n != IDLE || state != IDLE;
      wr_err     <= wr_en && !wr_ok;
    end
endmodule

// File: tb/tb_bcnn_frame_streamer.sv
// tb_bcnn_frame_streamer: directed scenarios for the frame streamer with a frame model
module tb_bcnn_frame_streamer;
  localparam int W = 28, H = 28, RW = 5, N = W * H;
  logic clk = 0, reset = 0, wr_en = 0, start = 0, pause = 0;
  logic [RW-1:0] wr_row = '0;
  logic [W-1:0] wr_data = '0;
  logic wr_err, pixel_out, valid_out, busy, frame_done;
  logic [W-1:0] mdl [H];
  logic got [N];
  int checks = 0, errors = 0;
  int n_valid, first_cyc, done_cyc, done_cnt, busy_fall, gaps, hold_bad, err_cnt, mism;

  bcnn_frame_streamer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ROW_W(RW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .wr_err(wr_err), .start(start), .pause(pause), .pixel_out(pixel_out),
    .valid_out(valid_out), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int r, input logic [W-1:0] d);
    wr_en = 1; wr_row = RW'(r); wr_data = d;
    step();
    wr_en = 0;
    mdl[r] = d;
  endtask

  // Starts a frame and records the stream until busy drops (or a cycle budget runs out).
  task automatic capture(input int pause_at, input int pause_len, input int inj_at,
                         input bit simul, input logic [W-1:0] sd);
    int left = 0;
    bit did = 0;
    logic last = 0;
    n_valid = 0; first_cyc = 0; done_cyc = 0; done_cnt = 0; busy_fall = 0;
    gaps = 0; hold_bad = 0; err_cnt = 0; mism = 0;
    start = 1;
    if (simul) begin wr_en = 1; wr_row = '0; wr_data = sd; mdl[0] = sd; end
    step();
    start = 0; wr_en = 0;
    for (int cyc = 1; cyc <= 2000 && busy_fall == 0; cyc++) begin
      if (cyc == inj_at) begin wr_en = 1; wr_row = RW'(5); wr_data = '1; end
      step();
      wr_en = 0;
      if (pause) begin left--; if (left == 0) pause = 0; end
      if (valid_out) begin
        if (first_cyc == 0) first_cyc = cyc;
        if (n_valid < N) begin
          got[n_valid] = pixel_out;
          if (pixel_out !== mdl[n_valid / W][n_valid % W]) mism++;
        end
        n_valid++;
        last = pixel_out;
      end else if (n_valid > 0 && n_valid < N) begin
        gaps++;
        if (pixel_out !== last) hold_bad++;
      end
      if (frame_done) begin done_cnt++; if (done_cyc == 0) done_cyc = cyc; end
      if (wr_err) err_cnt++;
      if (!busy) busy_fall = cyc;
      if (n_valid == pause_at && !did) begin pause = 1; left = pause_len; did = 1; end
    end
  endtask

  task automatic test_reset();
    reset = 0;
    step(); step();
    checks++; if (pixel_out !== 1'b0) begin errors++; $display("FAIL reset_pixel got %b exp 0", pixel_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done); end
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got %b exp 0", wr_err); end
    reset = 1;
    step();
  endtask

  task automatic test_basic();
    for (int r = 0; r < H; r++) write_row(r, r == 0 ? 28'h0000001 : 28'h0);
    capture(-1, 0, -1, 0, '0);
    checks++; if (n_valid != 784) begin errors++; $display("FAIL basic_count got %0d exp 784", n_valid); end
    checks++; if (mism != 0) begin errors++; $display("FAIL basic_pixels got %0d mismatching exp 0", mism); end
    checks++; if (got[0] !== 1'b1) begin errors++; $display("FAIL basic_first_pixel got %b exp 1", got[0]); end
    checks++; if (first_cyc != 1) begin errors++; $display("FAIL basic_first_cyc got %0d exp 1", first_cyc); end
    checks++; if (done_cyc != 785) begin errors++; $display("FAIL basic_done_cyc got %0d exp 785", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (busy_fall != 786) begin errors++; $display("FAIL basic_busy_fall got %0d exp 786", busy_fall); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL basic_gaps got %0d exp 0", gaps); end
  endtask

  task automatic test_pause();
    for (int r = 0; r < H; r++) write_row(r, r % 2 ? 28'h5555555 : 28'hAAAAAAA);
    capture(30, 3, -1, 0, '0);
    checks++; if (n_valid != 784) begin errors++; $display("FAIL pause_count got %0d exp 784", n_valid); end
    checks++; if (mism != 0) begin errors++; $display("FAIL pause_pixels got %0d mismatching exp 0", mism); end
    checks++; if (gaps != 3) begin errors++; $display("FAIL pause_gaps got %0d exp 3", gaps); end
    checks++; if (got[30] !== 1'b1) begin errors++; $display("FAIL pause_pixel31 got %b exp 1", got[30]); end
    checks++; if (got[29] !== 1'b0) begin errors++; $display("FAIL pause_pixel30 got %b exp 0", got[29]); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL pause_hold got %0d changes exp 0", hold_bad); end
    checks++; if (done_cyc != 788) begin errors++; $display("FAIL pause_done_cyc got %0d exp 788", done_cyc); end
  endtask

  task automatic test_wr_reject();
    logic [W-1:0] row5, row27;
    write_row(5, 28'h0F0F0F0);
    write_row(27, 28'h1234567);
    wr_en = 1; wr_row = RW'(28); wr_data = '1;
    step();
    wr_en = 0;
    checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL reject_oob_pulse got %b exp 1", wr_err); end
    step();
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reject_oob_clear got %b exp 0", wr_err); end
    capture(-1, 0, 100, 0, '0);
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL reject_stream_pulses got %0d exp 1", err_cnt); end
    capture(-1, 0, -1, 0, '0);
    for (int c = 0; c < W; c++) begin row5[c] = got[5 * W + c]; row27[c] = got[27 * W + c]; end
    checks++; if (row5 !== 28'h0F0F0F0) begin errors++; $display("FAIL reject_row5 got %h exp 0f0f0f0", row5); end
    checks++; if (row27 !== 28'h1234567) begin errors++; $display("FAIL reject_row27 got %h exp 1234567", row27); end
    checks++; if (mism != 0) begin errors++; $display("FAIL reject_pixels got %0d mismatching exp 0", mism); end
  endtask

  task automatic test_simul();
    int ones = 0;
    write_row(0, 28'h0);
    capture(-1, 0, -1, 1, '1);
    for (int i = 0; i < W; i++) ones += int'(got[i] === 1'b1);
    checks++; if (ones != 28) begin errors++; $display("FAIL simul_row0_ones got %0d exp 28", ones); end
    checks++; if (mism != 0) begin errors++; $display("FAIL simul_pixels got %0d mismatching exp 0", mism); end
    checks++; if (n_valid != 784) begin errors++; $display("FAIL simul_count got %0d exp 784", n_valid); end
  endtask

  task automatic test_reset_mid();
    int n = 0, dn = 0;
    start = 1;
    step();
    start = 0;
    for (int cyc = 0; cyc < 2000 && n < 400; cyc++) begin
      step();
      if (valid_out) n++;
    end
    checks++; if (n != 400) begin errors++; $display("FAIL midreset_reach got %0d exp 400", n); end
    reset = 0;
    step();
    reset = 1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", valid_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
    for (int i = 0; i < 4; i++) begin
      if (frame_done) dn++;
      step();
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL midreset_no_done got %0d exp 0", dn); end
    capture(-1, 0, -1, 0, '0);
    checks++; if (n_valid != 784) begin errors++; $display("FAIL midreset_count got %0d exp 784", n_valid); end
    checks++; if (mism != 0) begin errors++; $display("FAIL midreset_pixels got %0d mismatching exp 0", mism); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL midreset_done_cnt got %0d exp 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_wr_reject();
    test_simul();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcnn_frame_streamer.md
Name: bcnn_frame_streamer

Overview:
Transmit-side source for the binary CNN pipeline. It holds one binary input frame in an internal row buffer, loaded one row per write. On a start pulse it serializes the frame in row-major order as a 1-bit pixel stream with a valid qualifier, which drives the pixel_in/valid_in port of bcnn_conv3x3_top. A frame is emitted only while the block is not paused, and a done pulse marks the end of the frame.

Parameters:
IMG_WIDTH, 28, pixels per row; also the width of the row-write data.
IMG_HEIGHT, 28, rows per frame.
ROW_W, 5, width of the row address; must satisfy 2**ROW_W >= IMG_HEIGHT.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous reset, active-low (reset==0 resets).
wr_en  in  1  row-write strobe.
wr_row  in  ROW_W  row index of the write.
wr_data  in  IMG_WIDTH  row pixels; wr_data[c] is the pixel at column c.
wr_err  out  1  one-cycle pulse when a write is rejected.
start  in  1  frame-start request, sampled in IDLE only.
pause  in  1  holds the stream; no pixel is emitted while high.
pixel_out  out  1  stream pixel, to conv pixel_in.
valid_out  out  1  pixel qualifier, to conv valid_in.
busy  out  1  high while a frame is in progress.
frame_done  out  1  one-cycle pulse after the last pixel.

Behaviour:
- Reset (reset==0 at an edge):
  - pixel_out=0, valid_out=0, busy=0, frame_done=0, wr_err=0.
  - state=IDLE; row and column counters cleared.
  - Row buffer contents are not cleared.
  - Reset during STREAM aborts the frame immediately; no frame_done is produced.
- All outputs are registered.
- States: IDLE, STREAM, DONE.
- IDLE:
  - start==1 at edge E0 -> STREAM, r=0, c=0, busy=1 from the cycle after E0.
  - A start seen in any other state is ignored (not queued).
- STREAM, at each edge:
  - pause==0: pixel_out<=buf[r][c], valid_out<=1, then advance c; when c==IMG_WIDTH-1, set c=0 and r=r+1.
  - pause==1: valid_out<=0, pixel_out holds its value, counters hold.
  - At the edge emitting r=IMG_HEIGHT-1, c=IMG_WIDTH-1 -> DONE.
- DONE (one cycle): valid_out<=0, frame_done<=1 for exactly one cycle, then IDLE. busy stays high through the frame_done cycle and falls on the next edge.
- Latency:
  - First valid_out is high in the cycle after edge E0+1.
  - With pause held low, the frame is IMG_WIDTH*IMG_HEIGHT contiguous valid cycles, with no inter-row gap.
  - frame_done is high the cycle immediately after the last valid cycle.
- Writes:
  - Accepted only when state==IDLE and wr_row<IMG_HEIGHT; buf[wr_row]<=wr_data at that edge.
  - Otherwise the write is dropped and wr_err pulses for one cycle, with the buffer unchanged.
- Simultaneous wr_en and start in IDLE: the write commits at E0 and start is accepted. The stream reads the newly written data, because the first buffer read happens at E0+1.
- pause is ignored in IDLE and DONE.
- Counters are ROW_W bits for rows and clog2(IMG_WIDTH) bits for columns; they never wrap mid-frame.

Decomposition:
- Shared package bcnn_pkg holds:
  - IMG_WIDTH/IMG_HEIGHT defaults (28).
  - The streamer state encoding (IDLE=0, STREAM=1, DONE=2).
  - A clog2 helper for counter widths.
- Natural sub-module: bcnn_row_buffer. It is an IMG_HEIGHT x IMG_WIDTH register array with one write port (row-wide) and one registered bit-select read port (row, column).
- The FSM and counters stay in bcnn_frame_streamer.

Test Plan:
- Basic frame:
  - Stimulus: write row 0 = 28'h0000001, all other rows 0, then pulse start.
  - Response: exactly 784 valid cycles. Only the first pixel is 1. frame_done is high in cycle 785 after the first valid cycle. busy falls one cycle later.
- Pause:
  - Stimulus: checkerboard frame; assert pause for 3 cycles after the 30th valid pixel.
  - Response: valid_out is low for exactly 3 cycles. The 31st pixel equals buf[1][2]. Total valid count is still 784, and the pixel sequence is identical to the unpaused run.
- Write rejection:
  - Stimulus: wr_en with wr_row=28 in IDLE; wr_en with wr_row=5 during STREAM.
  - Response: wr_err pulses for one cycle each time. Re-streaming shows rows 5 and 27 unchanged.
- Simultaneous write and start:
  - Stimulus: wr_en with row 0 = all ones in the same cycle as start.
  - Response: the first 28 streamed pixels are 1.
- Reset mid-frame:
  - Stimulus: drive reset low for one edge at pixel 400.
  - Response: next cycle valid_out=0, busy=0, no frame_done. A new start streams 784 pixels from the buffer, whose contents are preserved.
- End-to-end:
  - Stimulus: feed the streamer into bcnn_conv3x3_top with the 28x28 "0" digit frame and weights 9'h1FF.
  - Response: conv valid_out count is 676 and matches the golden model.
